// File: rtl/resampler_pkg.sv
// ---------------------------------------------------------------------------
// resampler_pkg : shared types and constants for the resampler controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package resampler_pkg;

   localparam int DEPTH  = 16;
   localparam int FRAC_W = 20;
   localparam int MU_W   = 16;

   localparam logic [FRAC_W+1:0] STEP_ONE = 22'h100000;

   // Tap offsets relative to base_ptr, as 4-bit modular addresses.
   localparam logic [3:0] TAP_M2 = 4'hE;
   localparam logic [3:0] TAP_M1 = 4'hF;
   localparam logic [3:0] TAP_Z  = 4'h0;
   localparam logic [3:0] TAP_P1 = 4'h1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

endpackage : resampler_pkg

`default_nettype wire

// File: rtl/resampler_phase_acc.sv
// ---------------------------------------------------------------------------
// resampler_phase_acc : step register, fractional phase accumulator, k extract
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module resampler_phase_acc #(
   parameter int FRAC_W = 20,
   parameter int MU_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              load,
   input  logic [FRAC_W+1:0] step_in,
   input  logic              advance,
   output logic [2:0]        k,
   output logic [MU_W-1:0]   mu
);
   import resampler_pkg::*;

   localparam logic [FRAC_W+1:0] STEP_RST = {2'b01, {FRAC_W{1'b0}}};

   logic [FRAC_W+1:0] step_q, step_d;
   logic [FRAC_W-1:0] frac_q, frac_d;
   logic [FRAC_W+2:0] sum;

   always_comb begin
      sum    = (FRAC_W+3)'(frac_q) + (FRAC_W+3)'(step_q);
      k      = sum[FRAC_W+2:FRAC_W];
      step_d = load ? step_in : step_q;
      frac_d = frac_q;
      if (flush) begin
         frac_d = '0;
      end else if (advance) begin
         frac_d = sum[FRAC_W-1:0];
      end
   end

   assign mu = frac_q[FRAC_W-1 -: MU_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q <= STEP_RST;
         frac_q <= '0;
      end else begin
         step_q <= step_d;
         frac_q <= frac_d;
      end
   end

endmodule : resampler_phase_acc

`default_nettype wire

// File: rtl/resampler_ctrl.sv
// ---------------------------------------------------------------------------
// resampler_ctrl : sample-buffer and request controller for a 4-tap resampler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module resampler_ctrl #(
   parameter int DEPTH  = 16,
   parameter int FRAC_W = 20,
   parameter int MU_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [FRAC_W+1:0] step,
   input  logic              step_load,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              out_tick,
   output logic              out_req,
   input  logic              out_ack,
   output logic [3:0]        wr_ptr,
   output logic [3:0]        base_ptr,
   output logic [MU_W-1:0]   mu,
   output logic [4:0]        fill,
   output logic              overflow,
   output logic              underflow,
   input  logic              err_clr,
   output logic              cfg_err
);
   import resampler_pkg::*;

   localparam logic [3:0] BASE_RST = 4'd0 - TAP_M2;

   state_e     state_q, state_d;
   logic [3:0] wr_ptr_q, wr_ptr_d;
   logic [3:0] base_ptr_q, base_ptr_d;
   logic [4:0] fill_q, fill_d;
   logic       pending_q, pending_d;
   logic       overflow_q, overflow_d;
   logic       underflow_q, underflow_d;
   logic       cfg_err_q, cfg_err_d;

   logic       advance;
   logic       wr_en;
   logic       acc_load;
   logic [2:0] k;
   logic [2:0] k_eff;

   assign in_ready = (state_q != ST_IDLE) && (fill_q < 5'(DEPTH));
   assign out_req  = (state_q == ST_RUN) && pending_q && (fill_q >= 5'd4);
   assign advance  = out_req && out_ack;
   assign wr_en    = in_valid && in_ready;
   assign acc_load = (state_q == ST_IDLE) && step_load && (step != '0);
   assign k_eff    = advance ? k : 3'd0;

   resampler_phase_acc #(
      .FRAC_W (FRAC_W),
      .MU_W   (MU_W)
   ) u_phase_acc (
      .clk     (clk),
      .rst     (rst),
      .flush   (!enable),
      .load    (acc_load),
      .step_in (step),
      .advance (advance),
      .k       (k),
      .mu      (mu)
   );

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q + {3'b000, wr_en};
      base_ptr_d  = base_ptr_q + {1'b0, k_eff};
      fill_d      = fill_q + {4'b0000, wr_en} - {2'b00, k_eff};
      pending_d   = pending_q;
      cfg_err_d   = (state_q == ST_IDLE) && step_load && (step == '0);
      // A set in the same cycle as err_clr wins.
      overflow_d  = (overflow_q && !err_clr) ||
                    (in_valid && !in_ready && (state_q != ST_IDLE));
      underflow_d = (underflow_q && !err_clr) ||
                    ((state_q == ST_RUN) && out_tick && pending_q && !advance);

      if (advance) begin
         pending_d = 1'b0;
      end
      if ((state_q == ST_RUN) && out_tick) begin
         pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE:  state_d = ST_PRIME;
         ST_PRIME: if (fill_q >= 5'd4) state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase

      if (!enable) begin
         state_d    = ST_IDLE;
         wr_ptr_d   = 4'd0;
         base_ptr_d = BASE_RST;
         fill_d     = 5'd0;
         pending_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= 4'd0;
         base_ptr_q  <= BASE_RST;
         fill_q      <= 5'd0;
         pending_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         base_ptr_q  <= base_ptr_d;
         fill_q      <= fill_d;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign wr_ptr    = wr_ptr_q;
   assign base_ptr  = base_ptr_q;
   assign fill      = fill_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign cfg_err   = cfg_err_q;

endmodule : resampler_ctrl

`default_nettype wire

// File: tb/tb_resampler_ctrl.sv
// ---------------------------------------------------------------------------
// tb_resampler_ctrl : directed + randomized self-checking bench for resampler_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_resampler_ctrl;

   logic        clk = 1'b0;
   logic        rst, enable, step_load, in_valid, out_tick, out_ack, err_clr;
   logic [21:0] step;
   logic        in_ready, out_req, overflow, underflow, cfg_err;
   logic [3:0]  wr_ptr, base_ptr;
   logic [15:0] mu;
   logic [4:0]  fill;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // Reference model state: 0 idle, 1 priming, 2 running.
   int m_state, m_fill, m_wr, m_base, m_frac, m_step;
   bit m_pend, m_ovf, m_unf, m_cfg;

   always #5 clk = ~clk;

   resampler_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .step      (step),
      .step_load (step_load),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_tick  (out_tick),
      .out_req   (out_req),
      .out_ack   (out_ack),
      .wr_ptr    (wr_ptr),
      .base_ptr  (base_ptr),
      .mu        (mu),
      .fill      (fill),
      .overflow  (overflow),
      .underflow (underflow),
      .err_clr   (err_clr),
      .cfg_err   (cfg_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_ready();
      return (m_state != 0) && (m_fill < 16);
   endfunction

   function automatic bit m_req();
      return (m_state == 2) && m_pend && (m_fill >= 4);
   endfunction

   // Behavioural model: one update per rising edge from the inputs present then.
   task automatic model_step();
      bit adv, wr;
      int sum, k;
      if (rst) begin
         m_state = 0; m_fill = 0; m_wr = 0; m_base = 2; m_frac = 0;
         m_step = 'h100000; m_pend = 0; m_ovf = 0; m_unf = 0; m_cfg = 0;
         return;
      end
      adv = m_req() && out_ack;
      wr  = in_valid && m_ready();
      sum = m_frac + m_step;
      k   = adv ? sum / (1 << 20) : 0;
      m_ovf = (in_valid && !m_ready() && m_state != 0) ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
      m_unf = (m_state == 2 && out_tick && m_pend && !adv) ? 1'b1 : (err_clr ? 1'b0 : m_unf);
      m_cfg = (m_state == 0) && step_load && (step == 0);
      if (m_state == 0 && step_load && step != 0) m_step = int'(step);
      if (!enable) begin
         m_state = 0; m_fill = 0; m_wr = 0; m_base = 2; m_frac = 0; m_pend = 0;
      end else begin
         if (m_state == 2) begin
            if (adv) m_pend = 0;
            if (out_tick) m_pend = 1;
         end
         if (adv) m_frac = sum % (1 << 20);
         if (m_state == 0) m_state = 1;
         else if (m_state == 1 && m_fill >= 4) m_state = 2;
         m_fill = m_fill + int'(wr) - k;
         m_wr   = (m_wr + int'(wr)) % 16;
         m_base = (m_base + k) % 16;
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("in_ready",  32'(in_ready),  32'(m_ready()));
         chk("out_req",   32'(out_req),   32'(m_req()));
         chk("wr_ptr",    32'(wr_ptr),    32'(m_wr));
         chk("base_ptr",  32'(base_ptr),  32'(m_base));
         chk("mu",        32'(mu),        32'(m_frac >> 4));
         chk("fill",      32'(fill),      32'(m_fill));
         chk("overflow",  32'(overflow),  32'(m_ovf));
         chk("underflow", 32'(underflow), 32'(m_unf));
         chk("cfg_err",   32'(cfg_err),   32'(m_cfg));
      end
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ack_once();
      out_tick = 1'b1; cyc(); out_tick = 1'b0;
      out_ack  = 1'b1; cyc(); out_ack  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; step = 22'h100000; step_load = 1'b0;
      in_valid = 1'b0; out_tick = 1'b0; out_ack = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      repeat (2) cyc();
      chk_on = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_base_ptr", 32'(base_ptr), 32'd2);
      chk("rst_fill",     32'(fill),     32'd0);
      chk("rst_out_req",  32'(out_req),  32'd0);
      rst = 1'b0;

      // Zero step rejected; step must remain 1.0.
      step = '0; step_load = 1'b1; cyc(); step_load = 1'b0;
      chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
      cyc();
      chk("cfg_err_clear", 32'(cfg_err), 32'd0);

      // Unity rate.
      enable = 1'b1; cyc();
      chk("prime_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; repeat (4) cyc(); in_valid = 1'b0;
      chk("prime_fill", 32'(fill), 32'd4);
      cyc();
      chk("run_no_req", 32'(out_req), 32'd0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; out_tick = 1'b1; cyc(); in_valid = 1'b0; out_tick = 1'b0;
         chk("unity_req", 32'(out_req), 32'd1);
         out_ack = 1'b1; cyc(); out_ack = 1'b0;
         chk("unity_fill", 32'(fill), 32'd4);
         chk("unity_base", 32'(base_ptr), 32'(3 + i));
         chk("unity_mu",   32'(mu), 32'd0);
      end

      // Underflow with ack held low.
      out_tick = 1'b1; cyc(); cyc(); out_tick = 1'b0;
      chk("unf_flag", 32'(underflow), 32'd1);
      chk("unf_req",  32'(out_req),   32'd1);
      chk("unf_base", 32'(base_ptr),  32'd6);
      chk("unf_mu",   32'(mu),        32'd0);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      chk("unf_clr", 32'(underflow), 32'd0);
      out_ack = 1'b1; cyc(); out_ack = 1'b0;

      // Flush mid-RUN.
      enable = 1'b0; cyc();
      chk("flush_fill", 32'(fill),     32'd0);
      chk("flush_req",  32'(out_req),  32'd0);
      chk("flush_base", 32'(base_ptr), 32'd2);

      // Half rate, tick and ack every cycle.
      step = 22'h080000; step_load = 1'b1; cyc(); step_load = 1'b0;
      enable = 1'b1; cyc();
      in_valid = 1'b1; out_tick = 1'b1; out_ack = 1'b1;
      repeat (14) cyc();
      in_valid = 1'b0; out_tick = 1'b0; out_ack = 1'b0;
      enable = 1'b0; cyc();

      // Maximum step plus overflow.
      step = 22'h3FFFFF; step_load = 1'b1; cyc(); step_load = 1'b0;
      enable = 1'b1; cyc();
      in_valid = 1'b1; repeat (16) cyc();
      chk("full_fill",  32'(fill),     32'd16);
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_ovf0",  32'(overflow), 32'd0);
      cyc(); in_valid = 1'b0;
      chk("ovf_flag",  32'(overflow), 32'd1);
      chk("ovf_fill",  32'(fill),     32'd16);
      chk("ovf_wrptr", 32'(wr_ptr),   32'd0);
      ack_once();
      chk("max1_fill", 32'(fill),     32'd13);
      chk("max1_base", 32'(base_ptr), 32'd5);
      chk("max1_mu",   32'(mu),       32'hFFFF);
      in_valid = 1'b1; repeat (3) cyc(); in_valid = 1'b0;
      ack_once();
      chk("max2_fill", 32'(fill),     32'd12);
      chk("max2_base", 32'(base_ptr), 32'd9);
      ack_once();
      ack_once();
      chk("max_wrap_base", 32'(base_ptr), 32'd1);
      chk("max_wrap_fill", 32'(fill),     32'd4);
      chk("ovf_sticky",    32'(overflow), 32'd1);
      err_clr = 1'b1; cyc(); err_clr = 1'b0;
      chk("ovf_clr", 32'(overflow), 32'd0);
      enable = 1'b0; cyc();

      // Randomized traffic.
      for (int n = 0; n < 4000; n++) begin
         rst       = ($urandom_range(0, 199) == 0);
         enable    = ($urandom_range(0, 99) < 97);
         step_load = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 4))
            0:       step = 22'h000000;
            1:       step = 22'h080000;
            2:       step = 22'h100000;
            3:       step = 22'h3FFFFF;
            default: step = 22'($urandom_range(1, 32'h3FFFFF));
         endcase
         in_valid = ($urandom_range(0, 99) < 60);
         out_tick = ($urandom_range(0, 99) < 40);
         out_ack  = ($urandom_range(0, 99) < 60);
         err_clr  = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 299) == 0) enable = 1'b0;
         cyc();
      end
      rst = 1'b0; enable = 1'b0; step_load = 1'b0;
      in_valid = 1'b0; out_tick = 1'b0; out_ack = 1'b0; err_clr = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_resampler_ctrl

`default_nettype wire
